// File: rtl/flag_register_unit.sv
// NZCV producer: computes flags from the ALU op, holds them one stage, commits to arch.
// Define FLAG_BYPASS_EN to forward pending flags combinationally instead of raising busy.
module flag_register_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       flag_w,
    input  logic             flush,
    output logic [3:0]       Flags,
    output logic             flags_busy,
    output logic [WIDTH-1:0] alu_result
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_ORR = 2'b11;

    logic [WIDTH:0] add_full;
    logic [WIDTH:0] sub_full;
    logic           carry;
    logic           ovf;
    logic [3:0]     nzcv;
    logic [3:0]     merged;

    logic [3:0]     arch_q, arch_d;
    logic           pend_valid_q, pend_valid_d;
    logic [1:0]     pend_w_q, pend_w_d;
    logic [3:0]     pend_nzcv_q, pend_nzcv_d;

    assign add_full = {1'b0, src_a} + {1'b0, src_b};
    assign sub_full = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_result = '0;
        carry      = 1'b0;
        ovf        = 1'b0;
        unique case (alu_op)
            OP_ADD: begin
                alu_result = add_full[WIDTH-1:0];
                carry      = add_full[WIDTH];
                ovf        = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                             (add_full[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = sub_full[WIDTH-1:0];
                carry      = sub_full[WIDTH];
                ovf        = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                             (sub_full[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND: alu_result = src_a & src_b;
            OP_ORR: alu_result = src_a | src_b;
        endcase
        nzcv = {alu_result[WIDTH-1], alu_result == '0, carry, ovf};
    end

    // Arch flags with the pending entry's selected fields overlaid.
    always_comb begin
        merged[3:2] = pend_w_q[1] ? pend_nzcv_q[3:2] : arch_q[3:2];
        merged[1:0] = pend_w_q[0] ? pend_nzcv_q[1:0] : arch_q[1:0];
    end

    always_comb begin
        arch_d       = arch_q;
        pend_w_d     = pend_w_q;
        pend_nzcv_d  = pend_nzcv_q;
        pend_valid_d = alu_valid && (|flag_w) && !flush;
        if (pend_valid_q && !flush) begin
            arch_d = merged;
        end
        if (pend_valid_d) begin
            pend_w_d    = flag_w;
            pend_nzcv_d = nzcv;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arch_q       <= 4'b0000;
            pend_valid_q <= 1'b0;
            pend_w_q     <= 2'b00;
            pend_nzcv_q  <= 4'b0000;
        end else begin
            arch_q       <= arch_d;
            pend_valid_q <= pend_valid_d;
            pend_w_q     <= pend_w_d;
            pend_nzcv_q  <= pend_nzcv_d;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign Flags      = pend_valid_q ? merged : arch_q;
    assign flags_busy = 1'b0;
`else
    assign Flags      = arch_q;
    assign flags_busy = pend_valid_q;
`endif

endmodule

// File: tb/tb_flag_register_unit.sv
// Randomized + directed bench for flag_register_unit against a behavioural NZCV model.
module tb_flag_register_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic [1:0]  flag_w = 2'b00;
    logic        flush = 1'b0;
    logic [3:0]  Flags;
    logic        flags_busy;
    logic [31:0] alu_result;

    int checks = 0;
    int errors = 0;

    // model state: architectural flags plus a one-deep pending slot
    logic [3:0] m_arch;
    logic       m_pv;
    logic [1:0] m_pw;
    logic [3:0] m_pn;

    flag_register_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_op(alu_op),
        .src_a(src_a), .src_b(src_b), .flag_w(flag_w), .flush(flush),
        .Flags(Flags), .flags_busy(flags_busy), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [1:0] op,
                                               input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [3:0] ref_nzcv(input logic [1:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        longint unsigned u;
        longint s;
        logic c, v;
        r = ref_result(op, a, b);
        c = 1'b0;
        v = 1'b0;
        if (op == 2'd0) begin
            u = {32'b0, a} + {32'b0, b};
            c = u > 64'hFFFF_FFFF;
            s = longint'($signed(a)) + longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 2'd1) begin
            c = a >= b;
            s = longint'($signed(a)) - longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {r[31], r == 32'd0, c, v};
    endfunction

    function automatic logic [3:0] model_merged();
        logic [3:0] f;
        f = m_arch;
        if (m_pw[1]) f[3:2] = m_pn[3:2];
        if (m_pw[0]) f[1:0] = m_pn[1:0];
        return f;
    endfunction

    function automatic logic [3:0] exp_flags();
`ifdef FLAG_BYPASS_EN
        return m_pv ? model_merged() : m_arch;
`else
        return m_arch;
`endif
    endfunction

    function automatic logic exp_busy();
`ifdef FLAG_BYPASS_EN
        return 1'b0;
`else
        return m_pv;
`endif
    endfunction

    task automatic model_reset();
        m_arch = 4'b0;
        m_pv   = 1'b0;
        m_pw   = 2'b0;
        m_pn   = 4'b0;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] w, input logic fl);
        alu_valid = v;
        alu_op    = op;
        src_a     = a;
        src_b     = b;
        flag_w    = w;
        flush     = fl;
    endtask

    // one clock edge; model follows the same edge, sampled #1 later
    task automatic tick();
        logic nv;
        @(posedge clk);
        if (m_pv && !flush) m_arch = model_merged();
        nv = alu_valid && (flag_w != 2'b00) && !flush;
        if (nv) begin
            m_pw = flag_w;
            m_pn = ref_nzcv(alu_op, src_a, src_b);
        end
        m_pv = nv;
        #1;
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] w, input logic fl);
        drive(v, op, a, b, w, fl);
        tick();
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 2'b00, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (Flags !== 4'b0000 || flags_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: Flags=%b busy=%b want 0000/0", Flags, flags_busy);
        end
        step(1'b1, 2'd1, 32'd5, 32'd5, 2'b11, 1'b0);
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (Flags !== 4'b0000 || flags_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: Flags=%b busy=%b want 0000/0", Flags, flags_busy);
        end
        #2;
        reset = 1'b0;
        idle();
        idle();
        checks++;
        if (Flags !== 4'b0000 || flags_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_late_commit: Flags=%b busy=%b want 0000/0",
                     Flags, flags_busy);
        end
    endtask

    task automatic test_sub_equal();
        do_reset();
        step(1'b1, 2'd1, 32'd5, 32'd5, 2'b11, 1'b0);
        checks++;
`ifdef FLAG_BYPASS_EN
        if (Flags !== 4'b0110 || flags_busy !== 1'b0) begin
`else
        if (Flags !== 4'b0000 || flags_busy !== 1'b1) begin
`endif
            errors++;
            $display("FAIL sub_eq_issue: Flags=%b busy=%b want %b/%b",
                     Flags, flags_busy, exp_flags(), exp_busy());
        end
        idle();
        checks++;
        if (Flags !== 4'b0110 || flags_busy !== 1'b0) begin
            errors++;
            $display("FAIL sub_eq_commit: Flags=%b busy=%b want 0110/0", Flags, flags_busy);
        end
    endtask

    task automatic test_add_and();
        do_reset();
        step(1'b1, 2'd0, 32'h7FFF_FFFF, 32'd1, 2'b11, 1'b0);
        step(1'b1, 2'd2, 32'hF0, 32'h0F, 2'b10, 1'b0);
        checks++;
        if (Flags !== exp_flags() || flags_busy !== exp_busy()) begin
            errors++;
            $display("FAIL add_and_mid: Flags=%b busy=%b want %b/%b",
                     Flags, flags_busy, exp_flags(), exp_busy());
        end
        checks++;
        if (m_arch !== 4'b1001 || Flags[1:0] !== 2'b01) begin
            errors++;
            $display("FAIL add_ovf: Flags=%b want CV=01 (arch 1001)", Flags);
        end
        idle();
        checks++;
        if (Flags !== 4'b0101) begin
            errors++;
            $display("FAIL and_hold_cv: Flags=%b want 0101", Flags);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 2'd1, 32'd3, 32'd7, 2'b11, 1'b0);
        step(1'b1, 2'd0, 32'd1, 32'd1, 2'b01, 1'b0);
        checks++;
        if (Flags !== exp_flags() || flags_busy !== exp_busy()) begin
            errors++;
            $display("FAIL b2b_first: Flags=%b busy=%b want %b/%b",
                     Flags, flags_busy, exp_flags(), exp_busy());
        end
        checks++;
        if (m_arch !== 4'b1000 || flags_busy !== exp_busy()) begin
            errors++;
            $display("FAIL b2b_busy: busy=%b want %b", flags_busy, exp_busy());
        end
        idle();
        checks++;
        if (Flags !== 4'b1000 || flags_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final: Flags=%b busy=%b want 1000/0", Flags, flags_busy);
        end
    endtask

    task automatic test_flush();
        do_reset();
        step(1'b1, 2'd0, 32'hFFFF_FFFF, 32'd1, 2'b11, 1'b1);
        checks++;
        if (Flags !== 4'b0000 || flags_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_capture: Flags=%b busy=%b want 0000/0", Flags, flags_busy);
        end
        idle();
        checks++;
        if (Flags !== 4'b0000) begin
            errors++;
            $display("FAIL flush_no_commit: Flags=%b want 0000", Flags);
        end
        step(1'b1, 2'd0, 32'hFFFF_FFFF, 32'd1, 2'b11, 1'b0);
        idle();
        checks++;
        if (Flags !== 4'b0110) begin
            errors++;
            $display("FAIL add_wrap: Flags=%b want 0110", Flags);
        end
        step(1'b1, 2'd1, 32'd3, 32'd7, 2'b11, 1'b0);
        step(1'b0, 2'd0, 32'd0, 32'd0, 2'b00, 1'b1);
        idle();
        checks++;
        if (Flags !== 4'b0110 || flags_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_commit_edge: Flags=%b busy=%b want 0110/0",
                     Flags, flags_busy);
        end
    endtask

    task automatic test_orr();
        step(1'b1, 2'd3, 32'h8000_0000, 32'd0, 2'b11, 1'b0);
        idle();
        checks++;
        if (Flags !== 4'b1000) begin
            errors++;
            $display("FAIL orr_neg: Flags=%b want 1000", Flags);
        end
        step(1'b1, 2'd1, 32'd9, 32'd9, 2'b00, 1'b0);
        checks++;
        if (Flags !== 4'b1000 || flags_busy !== 1'b0) begin
            errors++;
            $display("FAIL no_write_op: Flags=%b busy=%b want 1000/0", Flags, flags_busy);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        logic [31:0] a, b;
        pool[0] = 32'h0;
        pool[1] = 32'h1;
        pool[2] = 32'h7FFF_FFFF;
        pool[3] = 32'h8000_0000;
        pool[4] = 32'hFFFF_FFFF;
        pool[5] = 32'h5;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, b,
                  2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (alu_result !== ref_result(alu_op, src_a, src_b)) begin
                errors++;
                $display("FAIL rand_result[%0d]: got %h want %h", i, alu_result,
                         ref_result(alu_op, src_a, src_b));
            end
            tick();
            checks++;
            if (Flags !== exp_flags() || flags_busy !== exp_busy()) begin
                errors++;
                $display("FAIL rand_flags[%0d]: Flags=%b busy=%b want %b/%b", i,
                         Flags, flags_busy, exp_flags(), exp_busy());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sub_equal();
        test_add_and();
        test_back_to_back();
        test_flush();
        test_orr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
